// File: rtl/mole_round_if.sv
// Handshake/status bundle between a whack-a-mole round controller and its host.
interface mole_round_if #(
  parameter int N_TGT   = 7,
  parameter int SCORE_W = 8,
  parameter int TMR_W   = 16,
  parameter int MISS_W  = 2
);
  logic               start;
  logic [N_TGT-1:0]   btn;
  logic [N_TGT-1:0]   pattern_in;
  logic [TMR_W-1:0]   round_len;
  logic [N_TGT-1:0]   targets;
  logic [SCORE_W-1:0] score;
  logic [MISS_W-1:0]  misses;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               wrong_pulse;
  logic               in_penalty;
  logic               game_over;

  modport master (
    output start, btn, pattern_in, round_len,
    input  targets, score, misses, hit_pulse, miss_pulse, wrong_pulse,
           in_penalty, game_over
  );

  modport slave (
    input  start, btn, pattern_in, round_len,
    output targets, score, misses, hit_pulse, miss_pulse, wrong_pulse,
           in_penalty, game_over
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// Round controller: loads a target pattern, times the round, scores hits,
// locks out wrong buttons behind a penalty window, ends the game on misses.
module mole_round_ctrl #(
  parameter int N_TGT    = 7,
  parameter int SCORE_W  = 8,
  parameter int TMR_W    = 16,
  parameter int PEN_CYC  = 250,
  parameter int MAX_MISS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  mole_round_if.slave bus
);
  localparam int MISS_W = $clog2(MAX_MISS + 1);
  localparam int PEN_W  = $clog2(PEN_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_PEN, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [N_TGT-1:0]   tgt_q, tgt_d, lock_q, lock_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_dec;
  logic [PEN_W-1:0]   pen_q, pen_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               hit_q, hit_d, missp_q, missp_d, wrong_q, wrong_d;
  logic [N_TGT-1:0]   wrong_bits;
  logic               is_hit, expire;

  // Round timer never wraps; a wrong press on the last tick leaves it at 0,
  // which PENALTY treats as already expired.
  assign tmr_dec    = (tmr_q == '0) ? '0 : tmr_q - TMR_W'(1);
  assign expire     = (tmr_q <= TMR_W'(1));
  assign wrong_bits = bus.btn & ~tgt_q & ~lock_q;
  assign is_hit     = ((bus.btn & tgt_q) == tgt_q);
  assign miss_inc   = miss_q + MISS_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      lock_q  <= '0;
      tmr_q   <= '0;
      pen_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      missp_q <= 1'b0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      lock_q  <= lock_d;
      tmr_q   <= tmr_d;
      pen_q   <= pen_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
      missp_q <= missp_d;
      wrong_q <= wrong_d;
    end
  end

  // Next-state logic; priority in ARMED is wrong press, then hit, then expiry.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    lock_d  = lock_q;
    tmr_d   = tmr_q;
    pen_d   = pen_q;
    score_d = score_q;
    miss_d  = miss_q;
    hit_d   = 1'b0;
    missp_d = 1'b0;
    wrong_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          score_d = '0;
          miss_d  = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tgt_d   = (bus.pattern_in == '0) ? N_TGT'(1) : bus.pattern_in;
        tmr_d   = (bus.round_len == '0) ? TMR_W'(1) : bus.round_len;
        lock_d  = '0;
        state_d = S_ARMED;
      end
      S_ARMED: begin
        tmr_d = tmr_dec;
        if (wrong_bits != '0) begin
          lock_d  = lock_q | wrong_bits;
          wrong_d = 1'b1;
          pen_d   = PEN_W'(PEN_CYC);
          state_d = S_PEN;
        end else if (is_hit) begin
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          hit_d   = 1'b1;
          state_d = S_LOAD;
        end else if (expire) begin
          missp_d = 1'b1;
          miss_d  = miss_inc;
          state_d = (miss_inc == MISS_W'(MAX_MISS)) ? S_OVER : S_LOAD;
        end
      end
      S_PEN: begin
        tmr_d = tmr_dec;
        pen_d = (pen_q == '0) ? '0 : pen_q - PEN_W'(1);
        if (expire) begin
          missp_d = 1'b1;
          miss_d  = miss_inc;
          state_d = (miss_inc == MISS_W'(MAX_MISS)) ? S_OVER : S_LOAD;
        end else if (pen_q <= PEN_W'(1)) begin
          state_d = S_ARMED;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.targets     = (state_q == S_ARMED || state_q == S_PEN) ? tgt_q : '0;
  assign bus.score       = score_q;
  assign bus.misses      = miss_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.miss_pulse  = missp_q;
  assign bus.wrong_pulse = wrong_q;
  assign bus.in_penalty  = (state_q == S_PEN);
  assign bus.game_over   = (state_q == S_OVER);
endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: single-round vector table plus
// hand-written lockout, game-over, penalty-expiry, saturation and reset runs.
module tb_mole_round_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mole_round_if #(.N_TGT(7), .SCORE_W(8), .TMR_W(16), .MISS_W(2)) bus();

  mole_round_ctrl #(.N_TGT(7), .SCORE_W(8), .TMR_W(16), .PEN_CYC(4), .MAX_MISS(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.btn = '0;
    bus.pattern_in = '0;
    bus.round_len = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Leaves the bench at the first ARMED sample point.
  task automatic start_round(input logic [6:0] pat, input logic [15:0] len);
    bus.pattern_in = pat;
    bus.round_len = len;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  // kind: 0 hit, 1 miss, 2 wrong, -1 none within budget.
  task automatic wait_strobe(input int budget, output int kind, output int edges);
    int n;
    kind = -1;
    edges = 0;
    while (edges < budget) begin
      tick();
      edges++;
      n = int'(bus.hit_pulse) + int'(bus.miss_pulse) + int'(bus.wrong_pulse);
      if (n != 0) begin
        chk("one_strobe", n, 1);
        kind = bus.hit_pulse ? 0 : (bus.miss_pulse ? 1 : 2);
        break;
      end
    end
  endtask

  typedef struct {
    logic [6:0]  pat;
    logic [15:0] len;
    logic [6:0]  btn;
    int          dly;
    logic [6:0]  tgt;
    int          kind;
    int          edges;
  } vec_t;

  vec_t vt[7];

  initial begin
    int k, e, cnt, wcnt, hseen, hits;
    logic [7:0] sc100;

    vt[0] = '{7'b0000101, 16'd100, 7'b0000101, 5, 7'b0000101, 0, 6};
    vt[1] = '{7'b0000000, 16'd100, 7'b0000001, 0, 7'b0000001, 0, 1};
    vt[2] = '{7'b1010000, 16'd50,  7'b1110000, 2, 7'b1010000, 2, 3};
    vt[3] = '{7'b0000011, 16'd20,  7'b0000001, 0, 7'b0000011, 1, 20};
    vt[4] = '{7'b0000001, 16'd0,   7'b0000000, 0, 7'b0000001, 1, 1};
    vt[5] = '{7'b0000110, 16'd4,   7'b0000110, 3, 7'b0000110, 0, 4};
    vt[6] = '{7'b1111111, 16'd10,  7'b1111111, 9, 7'b1111111, 0, 10};

    do_reset();
    chk("rst_targets", 32'(bus.targets), 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_misses", 32'(bus.misses), 0);
    chk("rst_flags", {bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse, bus.in_penalty, bus.game_over}, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      start_round(vt[i].pat, vt[i].len);
      chk($sformatf("v%0d_targets", i), 32'(bus.targets), 32'(vt[i].tgt));
      repeat (vt[i].dly) tick();
      bus.btn = vt[i].btn;
      wait_strobe(300, k, e);
      chk($sformatf("v%0d_kind", i), k, vt[i].kind);
      chk($sformatf("v%0d_edges", i), e + vt[i].dly, vt[i].edges);
      chk($sformatf("v%0d_score", i), 32'(bus.score), (vt[i].kind == 0) ? 1 : 0);
      chk($sformatf("v%0d_misses", i), 32'(bus.misses), (vt[i].kind == 1) ? 1 : 0);
      chk($sformatf("v%0d_in_pen", i), 32'(bus.in_penalty), (vt[i].kind == 2) ? 1 : 0);
      bus.btn = '0;
    end

    // Wrong press, 4-cycle penalty, then held extra button is locked out.
    do_reset();
    start_round(7'b0000001, 16'd100);
    bus.btn = 7'b0000010;
    tick();
    chk("lk_wrong", 32'(bus.wrong_pulse), 1);
    chk("lk_in_pen", 32'(bus.in_penalty), 1);
    bus.btn = 7'b0000011;
    cnt = 1; wcnt = 0; hseen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.in_penalty) cnt++;
      wcnt += int'(bus.wrong_pulse);
      if (bus.hit_pulse) begin hseen = 1; break; end
    end
    chk("lk_pen_cycles", cnt, 4);
    chk("lk_no_rewrong", wcnt, 0);
    chk("lk_hit", hseen, 1);
    chk("lk_score", 32'(bus.score), 1);

    // Now in LOAD with score 1: three expiries of 10-cycle rounds end the game.
    bus.btn = '0;
    bus.round_len = 16'd10;
    bus.pattern_in = 7'b1000000;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(100, k, e);
      chk($sformatf("go_miss%0d_kind", i), k, 1);
      chk($sformatf("go_miss%0d_gap", i), e, 11);
    end
    chk("go_misses", 32'(bus.misses), 3);
    chk("go_over", 32'(bus.game_over), 1);
    chk("go_targets", 32'(bus.targets), 0);
    repeat (3) tick();
    chk("go_hold_over", 32'(bus.game_over), 1);
    chk("go_hold_score", 32'(bus.score), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("go_restart_score", 32'(bus.score), 0);
    chk("go_restart_misses", 32'(bus.misses), 0);
    chk("go_restart_over", 32'(bus.game_over), 0);
    tick();
    chk("go_restart_tgt", 32'(bus.targets), 32'h40);

    // Round expires while in PENALTY.
    do_reset();
    start_round(7'b0000001, 16'd3);
    bus.btn = 7'b0000010;
    tick();
    chk("pe_wrong", 32'(bus.wrong_pulse), 1);
    bus.btn = '0;
    tick();
    chk("pe_in_pen", 32'(bus.in_penalty), 1);
    chk("pe_no_miss_yet", 32'(bus.miss_pulse), 0);
    tick();
    chk("pe_miss", 32'(bus.miss_pulse), 1);
    chk("pe_misses", 32'(bus.misses), 1);
    chk("pe_load_tgt", 32'(bus.targets), 0);
    tick();
    chk("pe_rearmed", 32'(bus.targets), 1);

    // Score saturation with a permanently held full pattern.
    do_reset();
    bus.btn = 7'h7f;
    start_round(7'h7f, 16'd100);
    hits = 0;
    sc100 = '0;
    for (int i = 0; i < 1000 && hits < 257; i++) begin
      tick();
      if (bus.hit_pulse) begin
        hits++;
        if (hits == 100) sc100 = bus.score;
      end
    end
    chk("sat_hits", hits, 257);
    chk("sat_score100", 32'(sc100), 100);
    chk("sat_score", 32'(bus.score), 255);
    bus.btn = '0;

    // Asynchronous reset in the middle of PENALTY.
    do_reset();
    start_round(7'b0000001, 16'd100);
    bus.btn = 7'b0000100;
    tick();
    chk("ar_in_pen", 32'(bus.in_penalty), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outs", {25'(bus.targets), bus.score, bus.misses, bus.hit_pulse, bus.miss_pulse,
                    bus.wrong_pulse, bus.in_penalty, bus.game_over}, 0);
    tick();
    rst_n = 1'b1;
    bus.btn = '0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(bus.hit_pulse) + int'(bus.miss_pulse) + int'(bus.wrong_pulse)
           + int'(bus.in_penalty) + int'(bus.game_over) + int'(bus.targets != '0);
    end
    chk("ar_idle_quiet", cnt, 0);
    start_round(7'b0101000, 16'd100);
    chk("ar_restart_tgt", 32'(bus.targets), 32'h28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
